// File: rtl/universal_counter_p_pkg.sv
// -----------------------------------------------------------------------------
// counter_pkg
// Shared definitions for the universal counter family.
//   cnt_mode_e    : boundary behaviour selector (wrap / saturate / one-shot).
//   CNT_DIR_UP    : dir value selecting an up count.
//   CNT_DIR_DOWN  : dir value selecting a down count.
// -----------------------------------------------------------------------------
package counter_pkg;

    typedef enum logic [1:0] {
        CNT_WRAP    = 2'b00,
        CNT_SAT     = 2'b01,
        CNT_ONESHOT = 2'b10,
        CNT_RSVD    = 2'b11
    } cnt_mode_e;

    localparam logic CNT_DIR_UP   = 1'b0;
    localparam logic CNT_DIR_DOWN = 1'b1;

endpackage : counter_pkg

// File: rtl/universal_counter_p_if.sv
// -----------------------------------------------------------------------------
// universal_counter_p_if
// Control and status bundle of the universal counter.
//   en        : count enable (gates the prescaler)
//   load_en   : synchronous load strobe
//   dir       : 0 = up, 1 = down
//   mode      : boundary mode (see counter_pkg::cnt_mode_e)
//   load_in   : load value
//   mod_max   : terminal (maximum) count value
//   count_out : registered count
//   tc        : registered terminal-count pulse
//   done      : sticky one-shot completion flag
// Handshake: there is no valid/ready pair; every control input is sampled
// on each rising clk edge and every status output is a registered level
// that is stable for the whole following cycle.
// Modports: master drives the controls, slave is the counter itself.
// -----------------------------------------------------------------------------
interface universal_counter_p_if #(
    parameter int WIDTH = 8
) ();

    logic             en;
    logic             load_en;
    logic             dir;
    logic [1:0]       mode;
    logic [WIDTH-1:0] load_in;
    logic [WIDTH-1:0] mod_max;
    logic [WIDTH-1:0] count_out;
    logic             tc;
    logic             done;

    modport master (
        output en, load_en, dir, mode, load_in, mod_max,
        input  count_out, tc, done
    );

    modport slave (
        input  en, load_en, dir, mode, load_in, mod_max,
        output count_out, tc, done
    );

endinterface : universal_counter_p_if

// File: rtl/universal_counter_p_prescaler.sv
// -----------------------------------------------------------------------------
// counter_prescaler
// Divides enabled cycles down to count ticks.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset
//   en   : advance the prescaler this cycle
//   clr  : synchronous clear (driven by the counter's load strobe)
//   tick : combinational; high on the enabled cycle that completes a period
// -----------------------------------------------------------------------------
module counter_prescaler #(
    parameter int PRESCALE = 1,
    parameter int PS_W     = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

    logic [PS_W-1:0] r_cnt;
    logic            w_last;

    // With PRESCALE=1 the register never leaves 0, so tick degenerates to en.
    assign w_last = (r_cnt == PS_LAST);
    assign tick   = en & w_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en) begin
            if (w_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule : counter_prescaler

// File: rtl/universal_counter_p.sv
// -----------------------------------------------------------------------------
// universal_counter_p
// Parametrised up/down counter with synchronous load, programmable terminal
// value, wrap / saturate / one-shot boundary modes and a clock-enable
// prescaler.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : universal_counter_p_if slave (controls in, count/tc/done out)
// Edge priority: rst > load_en > tick > hold.
// -----------------------------------------------------------------------------
module universal_counter_p
    import counter_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int PRESCALE = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    universal_counter_p_if.slave  bus
);

    localparam int PS_W = $clog2(PRESCALE) + 1;

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_done;

    logic             w_tick;
    logic             w_at_bound;
    logic [WIDTH-1:0] w_load_val;
    cnt_mode_e        w_mode;

    counter_prescaler #(
        .PRESCALE (PRESCALE),
        .PS_W     (PS_W)
    ) u_prescaler (
        .clk  (clk),
        .rst  (rst),
        .en   (bus.en),
        .clr  (bus.load_en),
        .tick (w_tick)
    );

    assign w_mode = cnt_mode_e'(bus.mode);

    // Up boundary uses >= so a mod_max lowered under the count still wraps
    // or holds on the next tick instead of running on to 2^WIDTH-1.
    assign w_at_bound = (bus.dir == CNT_DIR_UP) ? (r_count >= bus.mod_max)
                                                : (r_count == '0);

    assign w_load_val = (bus.load_in > bus.mod_max) ? bus.mod_max : bus.load_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
            r_tc    <= 1'b0;
            r_done  <= 1'b0;
        end else if (bus.load_en) begin
            r_count <= w_load_val;
            r_tc    <= 1'b0;
            r_done  <= 1'b0;
        end else if (w_tick && !r_done) begin
            if (w_at_bound) begin
                r_tc <= 1'b1;
                case (w_mode)
                    CNT_SAT: begin
                        r_count <= r_count;
                    end
                    CNT_ONESHOT: begin
                        r_count <= r_count;
                        r_done  <= 1'b1;
                    end
                    default: begin
                        // Wrap (reserved mode behaves the same).
                        r_count <= (bus.dir == CNT_DIR_UP) ? '0 : bus.mod_max;
                    end
                endcase
            end else begin
                r_tc    <= 1'b0;
                r_count <= (bus.dir == CNT_DIR_UP) ? r_count + 1'b1
                                                   : r_count - 1'b1;
            end
        end else begin
            r_tc <= 1'b0;
        end
    end

    assign bus.count_out = r_count;
    assign bus.tc        = r_tc;
    assign bus.done      = r_done;

endmodule : universal_counter_p
